// File: rtl/pwr_pkg.sv
// Shared types and defaults for the WFI sleep controller.
package pwr_pkg;

  // Debug-visible encoding: RUN=0, ENTER=1, SLEEP=2, WAKE=3.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StEnter = 2'd1,
    StSleep = 2'd2,
    StWake  = 2'd3
  } pwr_state_e;

  localparam int unsigned DefaultEntryDelay   = 4;
  localparam int unsigned DefaultSettleCycles = 16;

  // Width of a down-counter that must hold max(a, b) - 1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchronizer for asynchronous level inputs; all bits share one chain depth.
module sync_bits #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the sampled inputs down the chain; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/wfi_sleep_ctrl.sv
// WFI sleep controller: stalls the core, hands wfi to the PLL controller while asleep,
// and releases the core after a settle time once an interrupt is pending.
module wfi_sleep_ctrl
  import pwr_pkg::*;
#(
  parameter int unsigned ENTRY_DELAY   = DefaultEntryDelay,
  parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wfi_req,
  input  logic        irq_pending,
  input  logic        sleep_en,
  input  logic        cnt_clr,
  output logic        wfi_out,
  output logic        core_stall,
  output logic        wake_ack,
  output logic [1:0]  state_o,
  output logic [31:0] sleep_cycles
);

  localparam int unsigned CntW = cnt_width(ENTRY_DELAY, SETTLE_CYCLES);
  localparam logic [CntW-1:0] EntryLoad  = CntW'(ENTRY_DELAY - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  pwr_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            armed_q;
  logic [1:0]      sync_out;
  logic            wfi_s;
  logic            irq_s;

  sync_bits #(
    .WIDTH(2),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  ({irq_pending, wfi_req}),
    .q  (sync_out)
  );

  assign wfi_s   = sync_out[0];
  assign irq_s   = sync_out[1];
  assign state_o = state_q;

  // Sleep sequencing FSM; outputs are registered so wfi_out only moves on a clk edge
  // (or asynchronously to 0 on reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      wfi_out    <= 1'b0;
      core_stall <= 1'b0;
      wake_ack   <= 1'b0;
    end else begin
      wake_ack <= 1'b0;
      unique case (state_q)
        StRun: begin
          // Re-arm only once the request has been seen low, so a held wfi_req
          // cannot immediately re-enter after a wake.
          if (!wfi_s) armed_q <= 1'b1;
          if (wfi_s && sleep_en && !irq_s && armed_q) begin
            state_q    <= StEnter;
            cnt_q      <= EntryLoad;
            armed_q    <= 1'b0;
            core_stall <= 1'b1;
          end
        end
        StEnter: begin
          if (irq_s || !wfi_s || !sleep_en) begin
            state_q    <= StRun;
            wake_ack   <= 1'b1;
            core_stall <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= StSleep;
            wfi_out <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StSleep: begin
          // Only a pending interrupt wakes; a dropped wfi_req is ignored here.
          if (irq_s) begin
            state_q <= StWake;
            cnt_q   <= SettleLoad;
            wfi_out <= 1'b0;
          end
        end
        StWake: begin
          if (cnt_q == '0) begin
            state_q    <= StRun;
            wake_ack   <= 1'b1;
            core_stall <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Saturating residency counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sleep_cycles <= '0;
    end else if (cnt_clr) begin
      sleep_cycles <= '0;
    end else if (state_q == StSleep && sleep_cycles != '1) begin
      sleep_cycles <= sleep_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_wfi_sleep_ctrl.sv
// Bench for wfi_sleep_ctrl: vector table for the main sleep/wake/abort flow, then
// hand-written sequences for sleep_en abort, saturation, async reset and suppression.
module tb_wfi_sleep_ctrl;
  import pwr_pkg::*;

  typedef struct {
    logic        wfi;
    logic        irq;
    logic        en;
    logic        clr;
    pwr_state_e  st;
    logic        wo;
    logic        cs;
    logic        wa;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wfi_req;
  logic        irq_pending;
  logic        sleep_en;
  logic        cnt_clr;
  logic        wfi_out;
  logic        core_stall;
  logic        wake_ack;
  logic [1:0]  state_o;
  logic [31:0] sleep_cycles;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  wfi_sleep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wfi_req     (wfi_req),
    .irq_pending (irq_pending),
    .sleep_en    (sleep_en),
    .cnt_clr     (cnt_clr),
    .wfi_out     (wfi_out),
    .core_stall  (core_stall),
    .wake_ack    (wake_ack),
    .state_o     (state_o),
    .sleep_cycles(sleep_cycles)
  );

  function automatic vec_t mk(input logic w, input logic i, input logic en, input logic clr,
                              input pwr_state_e st, input logic wo, input logic cs,
                              input logic wa, input logic [31:0] cnt);
    vec_t v;
    v.wfi = w;  v.irq = i;  v.en = en;  v.clr = clr;
    v.st  = st; v.wo  = wo; v.cs = cs;  v.wa  = wa;  v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input vec_t e);
    n_vec++;
    if (state_o !== e.st || wfi_out !== e.wo || core_stall !== e.cs ||
        wake_ack !== e.wa || sleep_cycles !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: got st=%0d wfi_out=%b stall=%b ack=%b cnt=%h, want st=%0d wfi_out=%b stall=%b ack=%b cnt=%h",
               name, state_o, wfi_out, core_stall, wake_ack, sleep_cycles,
               e.st, e.wo, e.cs, e.wa, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    wfi_req     = v.wfi;
    irq_pending = v.irq;
    sleep_en    = v.en;
    cnt_clr     = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  task automatic run(input string name, input logic w, input logic i, input logic en,
                     input logic clr, input pwr_state_e st, input logic wo, input logic cs,
                     input logic wa, input logic [31:0] cnt);
    step(name, mk(w, i, en, clr, st, wo, cs, wa, cnt));
  endtask

  initial begin
    rst = 1'b1; wfi_req = 1'b0; irq_pending = 1'b0; sleep_en = 1'b1; cnt_clr = 1'b0;

    // Main flow: arm, enter (4), sleep, irq pulse, settle (16), wake, no re-entry,
    // re-arm, then abort on irq during the 2nd ENTER cycle.
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 1, 0, StRun,   0, 0, 0, 0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 0, 1, 0, StRun,   0, 0, 0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 1, 0, StEnter, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, StSleep, 1, 1, 0, k));
    vecs.push_back(mk(1, 1, 1, 0, StSleep, 1, 1, 0, 3));
    vecs.push_back(mk(1, 0, 1, 0, StSleep, 1, 1, 0, 4));
    for (int k = 0; k < 16; k++) vecs.push_back(mk(1, 0, 1, 0, StWake, 0, 1, 0, 5));
    vecs.push_back(mk(1, 0, 1, 0, StRun, 0, 0, 1, 5));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, StRun, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, StRun, 0, 0, 0, 5));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 0, 1, 0, StRun, 0, 0, 0, 5));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 1, 1, 0, StEnter, 0, 1, 0, 5));
    vecs.push_back(mk(1, 0, 1, 0, StRun, 0, 0, 1, 5));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 0, 1, 0, StRun, 0, 0, 0, 5));

    #2;
    check("reset", mk(0, 0, 1, 0, StRun, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) step($sformatf("tbl[%0d]", i), vecs[i]);

    // sleep_en dropping during ENTER aborts; the core is released without re-entry.
    run("en_rearm0", 0, 0, 1, 0, StRun,   0, 0, 0, 5);
    run("en_rearm1", 1, 0, 1, 0, StRun,   0, 0, 0, 5);
    run("en_rearm2", 1, 0, 1, 0, StRun,   0, 0, 0, 5);
    run("en_enter",  1, 0, 1, 0, StEnter, 0, 1, 0, 5);
    run("en_abort",  1, 0, 0, 0, StRun,   0, 0, 1, 5);
    run("en_after0", 1, 0, 1, 0, StRun,   0, 0, 0, 5);
    run("en_after1", 1, 0, 1, 0, StRun,   0, 0, 0, 5);

    // Saturation and clear while asleep.
    run("sat_rearm0", 0, 0, 1, 0, StRun, 0, 0, 0, 5);
    run("sat_rearm1", 1, 0, 1, 0, StRun, 0, 0, 0, 5);
    run("sat_rearm2", 1, 0, 1, 0, StRun, 0, 0, 0, 5);
    for (int k = 0; k < 4; k++) run("sat_enter", 1, 0, 1, 0, StEnter, 0, 1, 0, 5);
    run("sat_sleep0", 1, 0, 1, 0, StSleep, 1, 1, 0, 5);
    run("sat_sleep1", 1, 0, 1, 0, StSleep, 1, 1, 0, 6);
    force dut.sleep_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.sleep_cycles;
    for (int k = 0; k < 5; k++) run("sat_hold", 1, 0, 1, 0, StSleep, 1, 1, 0, 32'hFFFF_FFFF);
    run("sat_clr",  1, 0, 1, 1, StSleep, 1, 1, 0, 0);
    run("sat_post", 1, 0, 1, 0, StSleep, 1, 1, 0, 1);

    // Asynchronous reset between clk edges while asleep.
    #2;
    rst     = 1'b1;
    wfi_req = 1'b0;
    #1;
    check("async_rst", mk(0, 0, 1, 0, StRun, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sleep disabled with the request held high: stay in RUN.
    for (int k = 0; k < 100; k++) run("en_off", 1, 0, 0, 0, StRun, 0, 0, 0, 0);

    // Pending irq suppresses entry even when armed and enabled; entry follows once it clears.
    for (int k = 0; k < 3; k++) run("irq_pre", 1, 1, 0, 0, StRun, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) run("irq_supp", 1, 1, 1, 0, StRun, 0, 0, 0, 0);
    run("irq_drop0", 1, 0, 1, 0, StRun,   0, 0, 0, 0);
    run("irq_drop1", 1, 0, 1, 0, StRun,   0, 0, 0, 0);
    run("irq_enter", 1, 0, 1, 0, StEnter, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wfi_sleep_ctrl.md
WFI_SLEEP_CTRL -- requirements
Module: wfi_sleep_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_DELAY, default 4: clk cycles core_stall is held before wfi_out rises.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: clk cycles after wfi_out falls before the core is released.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on wfi_req and irq_pending.
REQ-004 clk  input  1  always-on 48-MHz HFOSC reference, the same net that drives pll_ctrl clk_ref.
REQ-005 rst  input  1  reset; one clock; asynchronous, active-high.
REQ-006 wfi_req  input  1  level from CPU; core-clock domain, asynchronous to clk.
REQ-007 irq_pending  input  1  OR of enabled interrupt sources; asynchronous to clk.
REQ-008 sleep_en  input  1  quasi-static; 0 disables sleep entry.
REQ-009 cnt_clr  input  1  synchronous clear of sleep_cycles.
REQ-010 wfi_out  output  1  registered; drives pll_ctrl wfi.
REQ-011 core_stall  output  1  registered; holds the CPU pipeline.
REQ-012 wake_ack  output  1  one-cycle pulse on return to RUN from ENTER, SLEEP or WAKE.
REQ-013 state_o  output  2  current FSM state, for debug.
REQ-014 sleep_cycles  output  32  saturating count of clk cycles spent in SLEEP.

Function
REQ-015 SHALL pass wfi_req and irq_pending through SYNC_STAGES flops; all FSM decisions use the synchronized values (wfi_s, irq_s).
REQ-016 FSM states: RUN=0, ENTER=1, SLEEP=2, WAKE=3.
REQ-017 RUN->ENTER when wfi_s=1, sleep_en=1, irq_s=0 and armed=1; load entry counter with ENTRY_DELAY-1.
REQ-018 armed: set in RUN when wfi_s=0; cleared on RUN->ENTER; prevents re-entry until wfi_req has been seen low.
REQ-019 ENTER: core_stall=1, wfi_out=0; decrement counter each cycle; at 0 with wfi_s=1 and irq_s=0 -> SLEEP.
REQ-020 ENTER abort: irq_s=1 or wfi_s=0 on any ENTER cycle -> RUN directly, pulse wake_ack, and never raise wfi_out.
REQ-021 SLEEP: wfi_out=1, core_stall=1; irq_s=1 -> WAKE and load settle counter with SETTLE_CYCLES-1.
REQ-022 SLEEP: wfi_s falling with irq_s=0 does not exit; only irq_s wakes.
REQ-023 WAKE: wfi_out=0, core_stall=1; decrement each cycle; at 0 -> RUN with wake_ack=1 for that cycle and core_stall=0 from the next cycle.
REQ-024 wfi_out SHALL change only on a clk edge, never combinationally, and SHALL be 1 only in SLEEP.
REQ-025 sleep_cycles SHALL increment by 1 per clk in SLEEP and saturate at 32'hFFFF_FFFF.
REQ-026 cnt_clr takes priority over increment; the counter is 0 the cycle after cnt_clr is sampled.
REQ-027 sleep_en falling during ENTER SHALL behave as an abort (REQ-020); during SLEEP or WAKE it is ignored.
REQ-028 irq_s=1 while wfi_s=1 in RUN SHALL suppress entry; the FSM stays in RUN.
REQ-029 SHALL accept ENTRY_DELAY >= 1 and SETTLE_CYCLES >= 1; counter widths are sized with $clog2.

Reset
REQ-030 Asynchronous rst SHALL force state=RUN, wfi_out=0, core_stall=0, wake_ack=0, armed=0, all counters 0 and synchronizer flops 0.
REQ-031 rst asserted in SLEEP SHALL drop wfi_out without waiting for a clk edge.
REQ-032 After rst release, entry SHALL require wfi_s to be seen low first (armed=0).

Structure
REQ-033 Package pwr_pkg SHALL hold the state enum and the default ENTRY_DELAY and SETTLE_CYCLES constants.
REQ-034 One sub-module, sync_bits (parameterized width and depth), SHALL implement REQ-015.

Verification
REQ-035 Release rst, then wfi_req low 3 cycles and high; no irq -> ENTER 4 cycles, SLEEP, wfi_out=1; irq pulse -> WAKE 16 cycles, wake_ack once, core_stall low the next cycle.
REQ-036 irq_pending rises on the 2nd ENTER cycle -> RUN, wake_ack=1, wfi_out stays 0 throughout.
REQ-037 wfi_req held high after wake -> no re-entry; drop wfi_req for 1 cycle and raise it -> new entry.
REQ-038 Preload sleep_cycles to 32'hFFFF_FFFE via force, stay in SLEEP 5 cycles -> reads 32'hFFFF_FFFF; cnt_clr -> 0.
REQ-039 rst asserted mid-SLEEP between clk edges -> wfi_out=0 and core_stall=0 immediately, state_o=0.
REQ-040 sleep_en=0 with wfi_req=1 for 100 cycles -> state stays RUN, sleep_cycles unchanged.
